// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry (ECALL) and return (MRET) sequencer.
// It holds the mstatus, mtvec, mepc and mcause CSRs and gives software access to them.
// Define CSR_MSCRATCH_EN to add mscratch at 0x340. Without it, 0x340 is unimplemented.
// Reset is synchronous and active-low on rst.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_type,
    input  logic [31:0] req_pc,
    input  logic        csr_valid,
    output logic        csr_ready,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;

    localparam logic [1:0] OpRw = 2'b01;
    localparam logic [1:0] OpRs = 2'b10;
    localparam logic [1:0] OpRc = 2'b11;

    localparam logic [31:0] CauseEcallM = 32'd11;

    typedef enum logic [1:0] {StIdle, StUpdate, StRedirect} state_e;

    state_e      state_q, state_d;
    logic        type_q;
    logic [29:0] pc_q;
    logic        mie_q, mpie_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] mstatus_rd;
    logic        req_fire, csr_we;
    logic [31:0] csr_wval;
`ifdef CSR_MSCRATCH_EN
    logic [31:0] mscratch_q;
`endif

    // MPP is hardwired to machine mode. Only MIE and MPIE are stored.
    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
    assign req_fire   = req_valid & req_ready;
    assign csr_we     = csr_valid & csr_ready & (csr_op != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> UPDATE -> REDIRECT -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (req_fire) state_d = StUpdate;
            StUpdate:   state_d = StRedirect;
            StRedirect: if (redirect_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs. A trap request takes priority over a CSR access in the same cycle.
    always_comb begin
        req_ready      = (state_q == StIdle);
        csr_ready      = (state_q == StIdle) & ~req_valid;
        redirect_valid = (state_q == StRedirect);
        busy           = (state_q != StIdle);
    end

    // Combinational CSR read of the addressed register's current value
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            AddrMstatus:  csr_rdata = mstatus_rd;
            AddrMtvec:    csr_rdata = mtvec_q;
            AddrMepc:     csr_rdata = mepc_q;
            AddrMcause:   csr_rdata = mcause_q;
`ifdef CSR_MSCRATCH_EN
            AddrMscratch: csr_rdata = mscratch_q;
`endif
            default:      csr_rdata = 32'd0;
        endcase
    end

    // Write value for RW, RS and RC operations, built from the old read value
    always_comb begin
        csr_wval = csr_rdata;
        case (csr_op)
            OpRw:    csr_wval = csr_wdata;
            OpRs:    csr_wval = csr_rdata | csr_wdata;
            OpRc:    csr_wval = csr_rdata & ~csr_wdata;
            default: csr_wval = csr_rdata;
        endcase
    end

    // Latch the accepted request for use in UPDATE
    always_ff @(posedge clk) begin
        if (!rst) begin
            type_q <= 1'b0;
            pc_q   <= 30'd0;
        end else if (req_fire) begin
            type_q <= req_type;
            pc_q   <= req_pc[31:2];
        end
    end

    // CSR state. Trap updates happen only in UPDATE and CSR writes only in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= 32'd0;
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
`ifdef CSR_MSCRATCH_EN
            mscratch_q <= 32'd0;
`endif
        end else if (state_q == StUpdate) begin
            if (!type_q) begin
                mepc_q   <= {pc_q, 2'b00};
                mcause_q <= CauseEcallM;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end else if (csr_we) begin
            case (csr_addr)
                AddrMstatus: begin
                    mie_q  <= csr_wval[3];
                    mpie_q <= csr_wval[7];
                end
                AddrMtvec:    mtvec_q  <= csr_wval;
                AddrMepc:     mepc_q   <= {csr_wval[31:2], 2'b00};
                AddrMcause:   mcause_q <= csr_wval;
`ifdef CSR_MSCRATCH_EN
                AddrMscratch: mscratch_q <= csr_wval;
`endif
                default: ;
            endcase
        end
    end

    // Redirect target is captured in UPDATE and held stable through REDIRECT.
    // The mtvec mode bits are dropped from the target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_pc_q <= 32'd0;
        end else if (state_q == StUpdate) begin
            redirect_pc_q <= type_q ? mepc_q : {mtvec_q[31:2], 2'b00};
        end
    end

    assign redirect_pc = redirect_pc_q;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-003 SHALL have port: req_valid  input  1  trap/return request from EXU.
REQ-004 SHALL have port: req_ready  output  1  request accepted when req_valid & req_ready.
REQ-005 SHALL have port: req_type  input  1  0 = ECALL (trap entry), 1 = MRET (trap return).
REQ-006 SHALL have port: req_pc  input  32  PC of the ECALL/MRET instruction.
REQ-007 SHALL have port: csr_valid  input  1  CSR instruction access request.
REQ-008 SHALL have port: csr_ready  output  1  CSR write committed when csr_valid & csr_ready.
REQ-009 SHALL have port: csr_addr  input  12  CSR address.
REQ-010 SHALL have port: csr_op  input  2  00 none/read-only, 01 RW, 10 RS (set), 11 RC (clear).
REQ-011 SHALL have port: csr_wdata  input  32  write operand (rs1 or zimm).
REQ-012 SHALL have port: csr_rdata  output  32  combinational old value of csr_addr.
REQ-013 SHALL have port: redirect_valid  output  1  PC redirect to IFU pending.
REQ-014 SHALL have port: redirect_ready  input  1  IFU takes the redirect.
REQ-015 SHALL have port: redirect_pc  output  32  new fetch PC, stable while redirect_valid.
REQ-016 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement CSRs mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; any other address reads 0 and writes are ignored.
REQ-018 SHALL use FSM IDLE -> UPDATE -> REDIRECT -> IDLE; req_ready = (state==IDLE).
REQ-019 SHALL, in IDLE on accepted request, latch req_type and req_pc and move to UPDATE next cycle.
REQ-020 SHALL, in UPDATE for ECALL: mepc <= {req_pc[31:2],2'b00}; mcause <= 32'd11; mstatus.MPIE <= MIE, MIE <= 0, MPP <= 2'b11; redirect_pc <= {mtvec[31:2],2'b00}.
REQ-021 SHALL, in UPDATE for MRET: mstatus.MIE <= MPIE, MPIE <= 1, MPP <= 2'b11; redirect_pc <= mepc.
REQ-022 SHALL hold redirect_valid = 1 throughout REDIRECT and return to IDLE in the cycle after redirect_valid & redirect_ready; earliest redirect_valid is 2 cycles after acceptance.
REQ-023 SHALL set csr_ready = (state==IDLE) & ~req_valid; a simultaneous request wins and the CSR access stalls.
REQ-024 SHALL compute write value: RW = wdata, RS = old|wdata, RC = old&~wdata; op 00 writes nothing.
REQ-025 SHALL force mepc[1:0] = 0 on every write; mtvec mode bits [1:0] stored but ignored for redirect.
REQ-026 SHALL treat mstatus bits other than MIE[3], MPIE[7], MPP[12:11] as read-zero, write-ignored; MPP reads 2'b11 always.

Reset
REQ-027 SHALL, when rst==0 at a clock edge: state IDLE, redirect_valid 0, redirect_pc 0, mstatus 0x1800, mtvec 0, mepc 0, mcause 0.
REQ-028 SHALL abort any in-flight trap on reset mid-operation; no partial CSR update survives, no redirect issued.

Configuration
REQ-029 SHALL, with CSR_MSCRATCH_EN defined, add mscratch at 0x340 (full 32-bit RW/RS/RC, reset 0).
REQ-030 SHALL, without CSR_MSCRATCH_EN, treat 0x340 as unimplemented (reads 0, writes ignored).

Verification
REQ-031 SHALL test: RW mtvec=0x80001003, then ECALL at pc 0x80000104 -> redirect_pc 0x80001000 two cycles later, mepc 0x80000104, mcause 11, mstatus MIE 0 / MPIE = prior MIE.
REQ-032 SHALL test: mepc=0x80000200, mstatus=0x1880, MRET -> redirect_pc 0x80000200, mstatus reads 0x1888.
REQ-033 SHALL test: redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable, req_ready 0, busy 1.
REQ-034 SHALL test: csr_valid and req_valid same cycle in IDLE -> csr_ready 0, trap taken, CSR write completes after return to IDLE.
REQ-035 SHALL test: RS 0x8 then RC 0x8 on mstatus -> reads 0x1808 then 0x1800; write 0x80000003 to mepc reads 0x80000000.
REQ-036 SHALL test: rst low in REDIRECT -> next cycle redirect_valid 0, all CSRs at reset values; 0x340 RW 0x1234 reads 0x1234 only with CSR_MSCRATCH_EN.
